// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction uses nine's complement of B plus an inverted borrow-in (ten's complement).
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic                  Sub,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  Cin,
  output logic [4*DIGITS-1:0]   Sum,
  output logic                  Cout,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Invalid
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic            load, last;
  logic [W-1:0]    a_q, b_q, sum_sh, sum_nx;
  logic            sub_q, c_q, c_nx, inv_acc, inv_nx;
  logic [CW-1:0]   cnt;
  logic [3:0]      a_d, b_d, bp, s;
  logic [4:0]      t;

  // Next-state and control decode
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(DIGITS - 1)) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // One decimal digit step on the current least-significant digits
  always_comb begin
    a_d  = a_q[3:0];
    b_d  = b_q[3:0];
    bp   = sub_q ? (4'd9 - b_d) : b_d;
    t    = 5'(a_d) + 5'(bp) + 5'(c_q);
    s    = t[3:0];
    c_nx = 1'b0;
    if (t > 5'd9) begin
      s    = 4'(t + 5'd6);
      c_nx = 1'b1;
    end
    sum_nx = (sum_sh >> 4) | (W'(s) << (W - 4));
    inv_nx = inv_acc | (a_d > 4'd9) | (b_d > 4'd9);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      cnt     <= '0;
      sum_sh  <= '0;
      inv_acc <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Invalid <= 1'b0;
    end else begin
      state <= state_nx;
      Busy  <= (state_nx == RUN);
      Done  <= (state_nx == DONE);
      if (load) begin
        a_q     <= A;
        b_q     <= B;
        sub_q   <= Sub;
        c_q     <= Sub ? ~Cin : Cin;
        cnt     <= '0;
        sum_sh  <= '0;
        inv_acc <= 1'b0;
      end else if (state == RUN) begin
        a_q     <= a_q >> 4;
        b_q     <= b_q >> 4;
        c_q     <= c_nx;
        cnt     <= cnt + CW'(1);
        sum_sh  <= sum_nx;
        inv_acc <= inv_nx;
        // Result registers change only when the final digit lands
        if (last) begin
          Sum     <= sum_nx;
          Cout    <= c_nx;
          Invalid <= inv_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: directed and random 4-digit ops plus an exhaustive 1-digit sweep,
// all checked against a plain decimal-arithmetic reference.
module tb_bcd_serial_addsub;

  logic        clk, rst;
  logic        Start, Sub, Cin, Cout, Busy, Done, Invalid;
  logic [15:0] A, B, Sum;
  logic        Start1, Sub1, Cin1, Cout1, Busy1, Done1, Invalid1;
  logic [3:0]  A1, B1, Sum1;

  int total = 0;
  int bad   = 0;

  bcd_serial_addsub #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
    .Sum(Sum), .Cout(Cout), .Busy(Busy), .Done(Done), .Invalid(Invalid)
  );

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .Start(Start1), .Sub(Sub1), .A(A1), .B(B1), .Cin(Cin1),
    .Sum(Sum1), .Cout(Cout1), .Busy(Busy1), .Done(Done1), .Invalid(Invalid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal reference: add mod 10^4 with carry, or subtract with no-borrow flag
  task automatic model(input logic [15:0] a, input logic [15:0] b, input bit sub, input bit cin,
                       output logic [15:0] es, output logic ec);
    int v;
    if (!sub) begin
      v  = bcd2int(a) + bcd2int(b) + int'(cin);
      ec = (v >= 10000);
      es = int2bcd(v % 10000);
    end else begin
      v  = bcd2int(a) - bcd2int(b) - int'(cin);
      ec = (v >= 0);
      es = int2bcd((v < 0) ? v + 10000 : v);
    end
  endtask

  // Issue one op (Start sampled at the next edge) and check timing, hold and result
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit sub, input bit cin,
                        input bit chk_sum, input bit exp_inv);
    logic [15:0] prev, es;
    logic        prevc, ec;
    int          n;
    bit          held;
    model(a, b, sub, cin, es, ec);
    A = a; B = b; Sub = sub; Cin = cin; Start = 1'b1;
    prev = Sum; prevc = Cout;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("busy_at_k", Busy, 1);
    chk("done_at_k", Done, 0);
    n = 0; held = 1'b1;
    while (!Done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (!Done && (Sum !== prev || Cout !== prevc || Busy !== 1'b1)) held = 1'b0;
    end
    chk("latency", n, 4);
    chk("hold_during_run", held, 1);
    chk("busy_at_done", Busy, 0);
    if (chk_sum) begin
      chk("sum", Sum, es);
      chk("cout", Cout, ec);
    end
    chk("invalid", Invalid, exp_inv);
  endtask

  initial begin
    logic [15:0] ra, rb, es;
    logic        ec;
    int          dcnt, mask, v;
    Start = 0; Sub = 0; Cin = 0; A = '0; B = '0;
    Start1 = 0; Sub1 = 0; Cin1 = 0; A1 = '0; B1 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {Sum, Cout, Busy, Done, Invalid}, '0);
    chk("reset_outputs_d1", {Sum1, Cout1, Busy1, Done1, Invalid1}, '0);
    rst = 1'b0;

    // Directed cases; the first Start is applied right as reset releases
    run_op(16'h1234, 16'h5678, 0, 0, 1, 0);
    chk("add_1234_5678", Sum, 16'h6912);
    run_op(16'h9999, 16'h0001, 0, 0, 1, 0);
    run_op(16'h0000, 16'h0000, 0, 1, 1, 0);
    run_op(16'h5000, 16'h1234, 1, 0, 1, 0);
    run_op(16'h0000, 16'h0001, 1, 0, 1, 0);
    chk("sub_wrap", {Sum, Cout}, {16'h9999, 1'b0});
    run_op(16'h0100, 16'h0099, 1, 1, 1, 0);
    run_op(16'h00A0, 16'h0000, 0, 0, 0, 1);
    run_op(16'h0001, 16'h0001, 0, 0, 1, 0);
    chk("after_invalid_sum", Sum, 16'h0002);

    // Random valid BCD operands
    for (int i = 0; i < 24; i++) begin
      ra = '0; rb = '0;
      for (int d = 0; d < 4; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(9));
        rb[4*d +: 4] = 4'($urandom_range(9));
      end
      run_op(ra, rb, bit'($urandom_range(1)), bit'($urandom_range(1)), 1, 0);
    end
    @(posedge clk); #1;

    // Start pulsed mid-run is ignored: exactly one Done with the original result
    model(16'h4321, 16'h1111, 0, 0, es, ec);
    A = 16'h4321; B = 16'h1111; Sub = 0; Cin = 0; Start = 1;
    @(posedge clk); #1; Start = 0;
    @(posedge clk); #1; Start = 1; A = 16'h9999; B = 16'h9999; Sub = 1;
    @(posedge clk); #1; Start = 0;
    dcnt = 0;
    for (int e = 0; e < 10; e++) begin
      if (Done) begin
        dcnt++;
        chk("ignored_start_sum", {Sum, Cout}, {es, ec});
      end
      @(posedge clk); #1;
    end
    chk("ignored_start_done_count", dcnt, 1);

    // Start held high: Done at k+4, k+9, k+14
    model(16'h1234, 16'h5678, 0, 0, es, ec);
    A = 16'h1234; B = 16'h5678; Sub = 0; Cin = 0; Start = 1;
    @(posedge clk); #1;
    dcnt = 0; mask = 0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      if (Done) begin
        dcnt++;
        mask = mask | (1 << e);
        chk("held_start_sum", {Sum, Cout}, {es, ec});
      end
      if (e == 14) Start = 0;
    end
    chk("held_start_done_count", dcnt, 3);
    chk("held_start_done_edges", mask, (1 << 4) | (1 << 9) | (1 << 14));
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-operation
    run_op(16'h2222, 16'h3333, 0, 1, 1, 0);
    A = 16'h1111; B = 16'h1111; Sub = 0; Cin = 0; Start = 1;
    @(posedge clk); #1; Start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {Sum, Cout, Busy, Done, Invalid}, '0);
    #2 rst = 1'b0;
    dcnt = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (Done) dcnt++;
    end
    chk("no_done_after_abort", dcnt, 0);
    chk("sum_lost_after_abort", Sum, 16'h0000);
    run_op(16'h0808, 16'h0202, 0, 0, 1, 0);
    @(posedge clk); #1;

    // Exhaustive single-digit sweep
    for (int sb = 0; sb < 2; sb++)
      for (int ci = 0; ci < 2; ci++)
        for (int a = 0; a < 10; a++)
          for (int b = 0; b < 10; b++) begin
            A1 = 4'(a); B1 = 4'(b); Sub1 = 1'(sb); Cin1 = 1'(ci); Start1 = 1;
            @(posedge clk); #1; Start1 = 0;
            chk("d1_busy", {Busy1, Done1}, 2'b10);
            @(posedge clk); #1;
            v = (sb != 0) ? (a - b - ci) : (a + b + ci);
            if (sb == 0) chk("d1_add", {Done1, Sum1, Cout1}, {1'b1, 4'(v % 10), v >= 10});
            else         chk("d1_sub", {Done1, Sum1, Cout1}, {1'b1, 4'((v < 0) ? v + 10 : v), v >= 0});
            chk("d1_invalid", Invalid1, 0);
          end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog timeout");
  end

endmodule
